// File: rtl/hash_stream_bridge_pkg.sv
// Shared types and elaboration helpers for the host <-> hash-core byte bridge.
package hash_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PUSH, S_READOUT, S_ERR
  } state_e;

  // Index width that stays >= 1 even for single-entry ranges.
  function automatic int lg2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // status carries {core_addr, byte_idx}, so both must fit in one host byte.
  function automatic bit params_ok(input int byte_w, input int word_bytes, input int addr_w);
    return (addr_w + $clog2(word_bytes)) <= byte_w;
  endfunction

endpackage

// File: rtl/hash_stream_bridge_if.sv
// Host pin handshake plus hash-core word/digest bus, seen from the bridge (master) and its peers (slave).
interface hash_stream_bridge_if #(
  parameter int BYTE_W       = 8,
  parameter int WORD_BYTES   = 4,
  parameter int DIGEST_BYTES = 32,
  parameter int ADDR_W       = 5
);
  logic [BYTE_W-1:0]              host_data;
  logic                           host_rdy;
  logic                           host_rq;
  logic                           host_done;
  logic                           host_err;
  logic [BYTE_W-1:0]              status;
  logic                           core_start;
  logic                           core_abort;
  logic [BYTE_W*WORD_BYTES-1:0]   core_data;
  logic                           core_rdy;
  logic [ADDR_W-1:0]              core_addr;
  logic                           core_rq;
  logic                           core_done;
  logic [BYTE_W*DIGEST_BYTES-1:0] core_digest;

  modport master (
    input  host_data, host_rdy, core_addr, core_rq, core_done, core_digest,
    output host_rq, host_done, host_err, status, core_start, core_abort, core_data, core_rdy
  );

  modport slave (
    output host_data, host_rdy, core_addr, core_rq, core_done, core_digest,
    input  host_rq, host_done, host_err, status, core_start, core_abort, core_data, core_rdy
  );
endinterface

// File: rtl/hash_stream_bridge_byte_handshake.sv
// Request/ack byte engine shared by word loading and digest readout: byte index plus host-stall timer.
module byte_handshake #(
  parameter int CNT_W       = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active_i,
  input  logic             clr_i,
  input  logic             rdy_i,
  input  logic [CNT_W-1:0] last_idx_i,
  output logic             rq_o,
  output logic             ack_o,
  output logic             last_o,
  output logic             tmo_o,
  output logic [CNT_W-1:0] idx_o
);
  logic             gap_q;
  logic [CNT_W-1:0] idx_q;

  // Request drops for the cycle after every ack so the host sees a fresh edge.
  assign rq_o   = active_i & ~gap_q;
  assign ack_o  = rq_o & rdy_i;
  assign last_o = ack_o & (idx_q == last_idx_i);
  assign idx_o  = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
      idx_q <= '0;
    end else if (clr_i) begin
      gap_q <= 1'b0;
      idx_q <= '0;
    end else begin
      gap_q <= ack_o;
      if (ack_o) idx_q <= idx_q + 1'b1;
    end
  end

  if (TIMEOUT_CYC > 0) begin : g_tmo
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q;

    assign tmo_o = rq_o & ~rdy_i & (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        tmo_q <= '0;
      else if (clr_i || !rq_o || rdy_i) tmo_q <= '0;
      else                               tmo_q <= tmo_q + 1'b1;
    end
  end else begin : g_no_tmo
    assign tmo_o = 1'b0;
  end

endmodule

// File: rtl/hash_stream_bridge.sv
// Byte-serial bridge: gathers host bytes into core words, then streams the latched digest back.
module hash_stream_bridge
  import hash_bridge_pkg::*;
#(
  parameter int BYTE_W       = 8,
  parameter int WORD_BYTES   = 4,
  parameter int DIGEST_BYTES = 32,
  parameter int ADDR_W       = 5,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic abort_i,
  input  logic le_mode_i,
  hash_stream_bridge_if.master bus
);
  localparam int CNT_W = lg2((WORD_BYTES > DIGEST_BYTES) ? WORD_BYTES : DIGEST_BYTES);
  localparam int WBI_W = lg2(WORD_BYTES);
  localparam int DBI_W = lg2(DIGEST_BYTES);
  localparam int WB_LG = $clog2(WORD_BYTES);

  if (!params_ok(BYTE_W, WORD_BYTES, ADDR_W)) begin : g_bad_params
    $error("hash_stream_bridge: ADDR_W + clog2(WORD_BYTES) exceeds BYTE_W");
  end

  state_e state_q, state_d;
  logic   start_q, core_rq_q, le_q, err_q, start_p_q, abort_p_q;
  logic [WORD_BYTES-1:0][BYTE_W-1:0]   data_q;
  logic [DIGEST_BYTES-1:0][BYTE_W-1:0] dig_q;

  logic             hs_rq, hs_ack, hs_last, hs_tmo, hs_clr, hs_active;
  logic [CNT_W-1:0] hs_idx, hs_last_idx;
  logic             start_rise, rq_rise;
  logic [WBI_W-1:0] wsel;
  logic [DBI_W-1:0] dsel;

  assign start_rise  = start_i & ~start_q;
  assign rq_rise     = bus.core_rq & ~core_rq_q;
  assign hs_active   = (state_q == S_LOAD) || (state_q == S_READOUT);
  assign hs_last_idx = (state_q == S_LOAD) ? CNT_W'(WORD_BYTES - 1) : CNT_W'(DIGEST_BYTES - 1);
  assign hs_clr      = (state_d != state_q);

  byte_handshake #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .active_i   (hs_active),
    .clr_i      (hs_clr),
    .rdy_i      (bus.host_rdy),
    .last_idx_i (hs_last_idx),
    .rq_o       (hs_rq),
    .ack_o      (hs_ack),
    .last_o     (hs_last),
    .tmo_o      (hs_tmo),
    .idx_o      (hs_idx)
  );

  // Priority inside each state: core_done > last byte > timeout; abort overrides all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_rise) state_d = S_FETCH;
      S_FETCH:   if (bus.core_done) state_d = S_READOUT;
                 else if (rq_rise)  state_d = S_LOAD;
      S_LOAD:    if (bus.core_done) state_d = S_READOUT;
                 else if (hs_last)  state_d = S_PUSH;
                 else if (hs_tmo)   state_d = S_ERR;
      S_PUSH:    state_d = bus.core_done ? S_READOUT : S_FETCH;
      S_READOUT: if (hs_last)       state_d = S_IDLE;
                 else if (hs_tmo)   state_d = S_ERR;
      S_ERR:     if (start_rise)    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  // First host byte lands in the most significant lane.
  assign wsel = WBI_W'(WORD_BYTES - 1) - hs_idx[WBI_W-1:0];
  assign dsel = le_q ? hs_idx[DBI_W-1:0] : DBI_W'(DIGEST_BYTES - 1) - hs_idx[DBI_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      core_rq_q <= 1'b0;
      le_q      <= 1'b0;
      err_q     <= 1'b0;
      start_p_q <= 1'b0;
      abort_p_q <= 1'b0;
      data_q    <= '0;
      dig_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_i;
      core_rq_q <= bus.core_rq;
      start_p_q <= (state_q == S_IDLE) && (state_d == S_FETCH);
      abort_p_q <= (abort_i && state_q != S_IDLE) || (state_d == S_ERR && state_q != S_ERR);
      if ((state_q == S_IDLE) && (state_d == S_FETCH)) le_q <= le_mode_i;
      if (abort_i || (state_q == S_ERR && state_d == S_IDLE)) err_q <= 1'b0;
      else if (state_d == S_ERR && state_q != S_ERR)          err_q <= 1'b1;
      if (state_q == S_LOAD && hs_ack && !abort_i) data_q[wsel] <= bus.host_data;
      if (state_d == S_READOUT && state_q != S_READOUT) dig_q <= bus.core_digest;
    end
  end

  always_comb begin
    bus.status = '0;
    if (state_q == S_READOUT)   bus.status = dig_q[dsel];
    else if (state_q != S_IDLE) bus.status = (BYTE_W'(bus.core_addr) << WB_LG) | BYTE_W'(hs_idx);
  end

  assign bus.host_rq    = hs_rq;
  assign bus.host_done  = (state_q == S_READOUT);
  assign bus.host_err   = err_q;
  assign bus.core_start = start_p_q;
  assign bus.core_abort = abort_p_q;
  assign bus.core_data  = data_q;
  assign bus.core_rdy   = (state_q == S_PUSH);

endmodule

// File: tb/tb_hash_stream_bridge.sv
// Directed-plus-random bench for hash_stream_bridge; host and core are emulated by tasks.
module tb_hash_stream_bridge;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, le_mode = 1'b0;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];

  hash_stream_bridge_if bus ();

  hash_stream_bridge #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .le_mode_i (le_mode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rq(input string tag);
    int n = 0;
    while (bus.host_rq !== 1'b1 && n < 50) begin step(); n++; end
    chk(tag, bus.host_rq, 1);
  endtask

  task automatic ack(input logic [7:0] d);
    bus.host_data = d;
    bus.host_rdy  = 1'b1;
    step();
    bus.host_rdy  = 1'b0;
    bus.host_data = 8'($urandom);
  endtask

  task automatic start_hash(input logic le);
    le_mode = le;
    start   = 1'b1;
    step();
    chk("core_start_pulse", bus.core_start, 1);
    start   = 1'b0;
    le_mode = ~le;
    step();
    chk("core_start_single", bus.core_start, 0);
  endtask

  // The core expects the first host byte in the top byte of the word.
  task automatic load_word(input logic [4:0] addr, input logic [31:0] w);
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    bus.core_addr = addr;
    bus.core_rq   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rq("load_rq");
      repeat ($urandom_range(0, 2)) step();
      chk("load_status", bus.status, {1'b0, addr, 2'(i)});
      ack(b[i]);
      if (i < 3) chk("load_gap", bus.host_rq, 0);
    end
    chk("word_rdy", bus.core_rdy, 1);
    chk("word_data", bus.core_data, w);
    bus.core_rq = 1'b0;
    step();
    chk("word_rdy_single", bus.core_rdy, 0);
  endtask

  // Expected readout: MSB-first byte list, or that list back to front for LSB-first.
  task automatic make_exp(input logic le, input logic [255:0] dig);
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      if (le) exp_q.push_front(dig[255-8*k -: 8]);
      else    exp_q.push_back(dig[255-8*k -: 8]);
    end
  endtask

  task automatic trigger_done(input logic [255:0] dig);
    bus.core_digest = dig;
    bus.core_done   = 1'b1;
    step();
    bus.core_done   = 1'b0;
    bus.core_digest = {8{$urandom}};
    chk("done_rise", bus.host_done, 1);
    chk("done_no_rdy", bus.core_rdy, 0);
  endtask

  task automatic read_bytes();
    for (int k = 0; k < 32; k++) begin
      wait_rq("rd_rq");
      if ($urandom_range(0, 3) == 0) step();
      chk("rd_byte", bus.status, exp_q[k]);
      ack(8'($urandom));
    end
    chk("rd_done_fall", bus.host_done, 0);
  endtask

  initial begin
    logic [255:0] dig;
    logic [31:0]  w;
    int           cnt, n;
    bus.host_data = '0; bus.host_rdy = 1'b0; bus.core_addr = '0;
    bus.core_rq = 1'b0; bus.core_done = 1'b0; bus.core_digest = '0;
    repeat (2) step();
    chk("rst_host_rq", bus.host_rq, 0);
    chk("rst_host_done", bus.host_done, 0);
    chk("rst_host_err", bus.host_err, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_abort", bus.core_abort, 0);
    chk("rst_core_rdy", bus.core_rdy, 0);
    chk("rst_core_data", bus.core_data, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_no_start", bus.core_start, 0);
    chk("idle_no_rq", bus.host_rq, 0);

    // Word loads then an MSB-first readout of 00..1F.
    start_hash(1'b0);
    load_word(5'd3, 32'hDEADBEEF);
    w = $urandom; load_word(5'($urandom), w);
    for (int k = 0; k < 32; k++) dig[255-8*k -: 8] = 8'(k);
    make_exp(1'b0, dig);
    trigger_done(dig);
    read_bytes();

    // Same digest, LSB-first.
    start_hash(1'b1);
    w = $urandom; load_word(5'($urandom), w);
    make_exp(1'b1, dig);
    trigger_done(dig);
    read_bytes();

    // Random digest, random byte order.
    le_mode = 1'($urandom);
    start_hash(le_mode);
    dig = {8{$urandom}};
    make_exp(~le_mode, dig);
    trigger_done(dig);
    read_bytes();

    // core_done with a half-loaded word.
    start_hash(1'b0);
    bus.core_addr = 5'd7; bus.core_rq = 1'b1;
    wait_rq("part_rq0"); ack(8'hA5);
    wait_rq("part_rq1"); ack(8'h5A);
    dig = {8{$urandom}};
    make_exp(1'b0, dig);
    bus.core_digest = dig; bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0; bus.core_rq = 1'b0; bus.core_digest = '0;
    chk("part_no_rdy", bus.core_rdy, 0);
    chk("part_done", bus.host_done, 1);
    chk("part_first_byte", bus.status, dig[255:248]);
    read_bytes();

    // Host stall until timeout.
    start_hash(1'b0);
    bus.core_addr = 5'd1; bus.core_rq = 1'b1;
    wait_rq("tmo_rq");
    cnt = 0; n = 0;
    while (bus.host_err !== 1'b1 && n < 40) begin
      if (bus.host_rq === 1'b1) cnt++;
      step(); n++;
    end
    chk("tmo_cycles", cnt, 16);
    chk("tmo_err", bus.host_err, 1);
    chk("tmo_abort", bus.core_abort, 1);
    chk("tmo_rq_clear", bus.host_rq, 0);
    bus.core_rq = 1'b0;
    step();
    chk("tmo_abort_single", bus.core_abort, 0);
    chk("tmo_err_held", bus.host_err, 1);
    start = 1'b1;
    step();
    chk("err_exit_clear", bus.host_err, 0);
    chk("err_exit_no_start", bus.core_start, 0);
    step();
    chk("err_exit_no_start2", bus.core_start, 0);
    start = 1'b0;
    step();

    // Abort mid-readout with start held high.
    start_hash(1'b1);
    dig = {8{$urandom}};
    make_exp(1'b1, dig);
    trigger_done(dig);
    for (int k = 0; k < 5; k++) begin
      wait_rq("ab_rq");
      chk("ab_byte", bus.status, exp_q[k]);
      ack(8'($urandom));
    end
    start = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_done_clear", bus.host_done, 0);
    chk("ab_core_abort", bus.core_abort, 1);
    chk("ab_rq_clear", bus.host_rq, 0);
    step();
    chk("ab_core_abort_single", bus.core_abort, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_start_level", bus.core_start, 0);
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("ab_restart", bus.core_start, 1);
    start = 1'b0;
    step();

    // Asynchronous reset in the middle of a word load.
    bus.core_addr = 5'd2; bus.core_rq = 1'b1;
    wait_rq("ar_rq0"); ack(8'h11);
    wait_rq("ar_rq1");
    #2 rst_n = 1'b0;
    #1;
    chk("ar_host_rq", bus.host_rq, 0);
    chk("ar_status", bus.status, 0);
    chk("ar_core_data", bus.core_data, 0);
    chk("ar_host_done", bus.host_done, 0);
    chk("ar_core_rdy", bus.core_rdy, 0);
    bus.core_rq = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    bus.core_rq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_idle_rq", bus.host_rq, 0);
      chk("ar_idle_start", bus.core_start, 0);
    end
    bus.core_rq = 1'b0;
    step();
    start_hash(1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("final_abort", bus.core_abort, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
